// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix driver and its strip receiver.
package matrix_pkg;

    localparam int         START_ZEROS = 32;
    localparam int         WORD_BITS   = 32;
    localparam logic [2:0] LED_HDR     = 3'b111;
    localparam int         MATRIX_W    = 8;

    // Receiver framing states.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARMED = 2'd1,
        WORD  = 2'd2
    } rx_state_e;

    // Strip position to bitmap position. Even rows run right-to-left on the
    // strip, so their column is mirrored; odd rows map straight through.
    function automatic logic [5:0] snake_to_display(input logic [5:0] k);
        logic [2:0] row;
        logic [2:0] col;
        row = k[5:3];
        col = k[2:0];
        if (!row[0]) begin
            return {row, 3'd7 - col};
        end
        return k;
    endfunction

endpackage

// File: rtl/strip_sync_edge.sv
// Brings the strip clock/data into the clk domain and strobes each rising
// strip-clock edge together with the data bit sampled at that edge.
module strip_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sclk_i,
    input  logic sdata_i,
    output logic rise_o,
    output logic bit_o
);

    logic [1:0] sclk_sync_q;
    logic [1:0] sdata_sync_q;
    logic       sclk_prev_q;
    logic       rise_q;
    logic       bit_q;

    // Two-flop synchronisers, then a registered edge strobe and bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q  <= 2'b00;
            sdata_sync_q <= 2'b00;
            sclk_prev_q  <= 1'b0;
            rise_q       <= 1'b0;
            bit_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], sclk_i};
            sdata_sync_q <= {sdata_sync_q[0], sdata_i};
            sclk_prev_q  <= sclk_sync_q[1];
            rise_q       <= sclk_sync_q[1] & ~sclk_prev_q;
            bit_q        <= sdata_sync_q[1];
        end
    end

    assign rise_o = rise_q;
    assign bit_o  = bit_q;

endmodule

// File: rtl/apa102_matrix_rx.sv
// Two-wire LED strip receiver: finds frame delimiters, decodes 32-bit LED
// words, reports each pixel and rebuilds the 8x8 on/off bitmap.
// Bit stream handshake: the sync stage presents one (rise, bit) strobe per
// strip-clock edge; there is no back-pressure, every strobe is consumed.
module apa102_matrix_rx
    import matrix_pkg::*;
#(
    parameter int          NUM_LEDS    = 64,
    parameter logic [23:0] FG_COLOUR   = 24'h000f00,
    parameter int          START_ZEROS = matrix_pkg::START_ZEROS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk_in,
    input  logic        sdata_in,
    output logic        led_valid,
    output logic [5:0]  led_index,
    output logic [4:0]  led_bright,
    output logic [7:0]  led_b,
    output logic [7:0]  led_g,
    output logic [7:0]  led_r,
    output logic        frame_done,
    output logic [6:0]  led_count,
    output logic [63:0] frame_bits,
    output logic        frame_err,
    output rx_state_e   dbg_state_o
);

    localparam int          ZW       = $clog2(START_ZEROS + 1);
    localparam logic [ZW-1:0] ZMAX   = ZW'(START_ZEROS);
    localparam logic [6:0]  LED_MAX  = 7'(NUM_LEDS);
    localparam logic [4:0]  LAST_BIT = 5'(WORD_BITS - 1);

    logic rise;
    logic bit_in;

    strip_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .sclk_i  (sclk_in),
        .sdata_i (sdata_in),
        .rise_o  (rise),
        .bit_o   (bit_in)
    );

    rx_state_e     state_q;
    logic [ZW-1:0] zcount_q;
    logic [4:0]    bitcnt_q;
    logic [30:0]   shift_q;
    logic [6:0]    led_ptr_q;
    logic [63:0]   shadow_q;

    logic          led_valid_q;
    logic [5:0]    led_index_q;
    logic [4:0]    led_bright_q;
    logic [7:0]    led_b_q;
    logic [7:0]    led_g_q;
    logic [7:0]    led_r_q;
    logic          frame_done_q;
    logic [6:0]    led_count_q;
    logic [63:0]   frame_bits_q;
    logic          frame_err_q;

    logic [31:0]   word_d;
    logic [5:0]    disp_d;

    // Word as it stands once the current bit is shifted in, and its bitmap slot.
    always_comb begin
        word_d = {shift_q, bit_in};
        disp_d = snake_to_display(led_ptr_q[5:0]);
    end

    // Framing FSM with registered pulse and field outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            zcount_q     <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            led_ptr_q    <= '0;
            shadow_q     <= '0;
            led_valid_q  <= 1'b0;
            led_index_q  <= '0;
            led_bright_q <= '0;
            led_b_q      <= '0;
            led_g_q      <= '0;
            led_r_q      <= '0;
            frame_done_q <= 1'b0;
            led_count_q  <= '0;
            frame_bits_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            led_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (rise) begin
                case (state_q)
                    HUNT: begin
                        if (bit_in) begin
                            zcount_q <= '0;
                        end else if (zcount_q == ZMAX - 1'b1) begin
                            state_q   <= ARMED;
                            zcount_q  <= ZMAX;
                            led_ptr_q <= '0;
                        end else begin
                            zcount_q <= zcount_q + 1'b1;
                        end
                    end
                    ARMED: begin
                        if (bit_in) begin
                            state_q  <= WORD;
                            shift_q  <= 31'd1;
                            bitcnt_q <= 5'd1;
                        end else if (zcount_q != ZMAX) begin
                            if ((zcount_q == ZMAX - 1'b1) && (led_ptr_q != '0)) begin
                                // Delimiter after at least one LED: publish the frame.
                                frame_done_q <= 1'b1;
                                frame_bits_q <= shadow_q;
                                led_count_q  <= led_ptr_q;
                                shadow_q     <= '0;
                                led_ptr_q    <= '0;
                                zcount_q     <= '0;
                            end else begin
                                zcount_q <= zcount_q + 1'b1;
                            end
                        end
                    end
                    WORD: begin
                        shift_q  <= word_d[30:0];
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) begin
                            zcount_q <= '0;
                            if (word_d[31:29] == LED_HDR) begin
                                state_q <= ARMED;
                                // Words past the last captured LED are dropped silently.
                                if (led_ptr_q < LED_MAX) begin
                                    led_valid_q      <= 1'b1;
                                    led_index_q      <= led_ptr_q[5:0];
                                    led_bright_q     <= word_d[28:24];
                                    led_b_q          <= word_d[23:16];
                                    led_g_q          <= word_d[15:8];
                                    led_r_q          <= word_d[7:0];
                                    shadow_q[disp_d] <= (word_d[23:0] == FG_COLOUR);
                                    led_ptr_q        <= led_ptr_q + 1'b1;
                                end
                            end else begin
                                // Bad header: abandon the frame and resynchronise.
                                frame_err_q <= 1'b1;
                                shadow_q    <= '0;
                                led_ptr_q   <= '0;
                                state_q     <= HUNT;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign led_valid   = led_valid_q;
    assign led_index   = led_index_q;
    assign led_bright  = led_bright_q;
    assign led_b       = led_b_q;
    assign led_g       = led_g_q;
    assign led_r       = led_r_q;
    assign frame_done  = frame_done_q;
    assign led_count   = led_count_q;
    assign frame_bits  = frame_bits_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apa102_matrix_rx.sv
// Bench for apa102_matrix_rx: drives strip bit streams, records every output
// event and compares against a frame parser run over the recorded stream.
module tb_apa102_matrix_rx;

  localparam int          NUM_LEDS = 64;
  localparam int          SZ       = 32;
  localparam logic [23:0] FG       = 24'h000f00;

  logic        clk;
  logic        reset;
  logic        sclk_in;
  logic        sdata_in;
  logic        led_valid;
  logic [5:0]  led_index;
  logic [4:0]  led_bright;
  logic [7:0]  led_b;
  logic [7:0]  led_g;
  logic [7:0]  led_r;
  logic        frame_done;
  logic [6:0]  led_count;
  logic [63:0] frame_bits;
  logic        frame_err;
  matrix_pkg::rx_state_e dbg_state;

  apa102_matrix_rx #(
    .NUM_LEDS    (NUM_LEDS),
    .FG_COLOUR   (FG),
    .START_ZEROS (SZ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk_in     (sclk_in),
    .sdata_in    (sdata_in),
    .led_valid   (led_valid),
    .led_index   (led_index),
    .led_bright  (led_bright),
    .led_b       (led_b),
    .led_g       (led_g),
    .led_r       (led_r),
    .frame_done  (frame_done),
    .led_count   (led_count),
    .frame_bits  (frame_bits),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [34:0] exp_led_q[$];
  logic [70:0] exp_frm_q[$];
  logic [34:0] obs_led_q[$];
  logic [70:0] obs_frm_q[$];
  bit          stream[$];
  int          exp_err;
  int          obs_err;
  int          chk_led;
  int          chk_frm;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: collect every output pulse outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (led_valid) obs_led_q.push_back({led_index, led_bright, led_b, led_g, led_r});
      if (frame_done) obs_frm_q.push_back({led_count, frame_bits});
      if (frame_err) obs_err++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int disp(input int k);
    int row;
    int c;
    row = k / 8;
    c   = k % 8;
    if (row % 2 == 0) return row * 8 + 7 - c;
    return k;
  endfunction

  // Parse the whole stream since reset into expected pixels, frames, errors.
  task automatic model_run();
    int          i;
    int          n;
    int          run;
    int          zrun;
    int          ptr;
    bit          armed;
    logic [63:0] shadow;
    logic [31:0] w;
    exp_led_q.delete();
    exp_frm_q.delete();
    exp_err = 0;
    n = stream.size();
    i = 0; run = 0; zrun = 0; ptr = 0; armed = 0; shadow = '0;
    while (i < n) begin
      if (!armed) begin
        if (stream[i]) run = 0;
        else run++;
        i++;
        if (run == SZ) begin
          armed = 1; zrun = SZ; ptr = 0;
        end
      end else if (stream[i]) begin
        if (i + 32 > n) break;
        for (int j = 0; j < 32; j++) w[31-j] = stream[i+j];
        i += 32;
        zrun = 0;
        if (w[31:29] != 3'b111) begin
          exp_err++; armed = 0; run = 0; ptr = 0; shadow = '0;
        end else if (ptr < NUM_LEDS) begin
          exp_led_q.push_back({6'(ptr), w[28:24], w[23:16], w[15:8], w[7:0]});
          shadow[disp(ptr)] = (w[23:0] == FG);
          ptr++;
        end
      end else begin
        i++;
        if (zrun < SZ) begin
          zrun++;
          if (zrun == SZ && ptr > 0) begin
            exp_frm_q.push_back({7'(ptr), shadow});
            shadow = '0; ptr = 0; zrun = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    repeat (8) @(negedge clk);
    model_run();
    check_eq("n_led", obs_led_q.size(), exp_led_q.size());
    check_eq("n_frame", obs_frm_q.size(), exp_frm_q.size());
    check_eq("n_err", obs_err, exp_err);
    for (int i = chk_led; i < exp_led_q.size() && i < obs_led_q.size(); i++)
      check_eq("led_evt", obs_led_q[i], exp_led_q[i]);
    for (int i = chk_frm; i < exp_frm_q.size() && i < obs_frm_q.size(); i++)
      check_eq("frame_evt", obs_frm_q[i], exp_frm_q[i]);
    chk_led = exp_led_q.size();
    chk_frm = exp_frm_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input bit b);
    @(negedge clk);
    sclk_in  = 1'b0;
    sdata_in = b;
    @(negedge clk);
    @(negedge clk);
    sclk_in = 1'b1;
    @(negedge clk);
    stream.push_back(b);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(w[31-i]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [4:0]  br;
    logic [23:0] col;
    br  = 5'($urandom_range(0, 31));
    col = ($urandom_range(0, 3) == 0) ? FG : 24'($urandom);
    return {3'b111, br, col};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b1;
    sclk_in = 1'b0;
    sdata_in = 1'b0;
    @(negedge clk);
    obs_led_q.delete();
    obs_frm_q.delete();
    stream.delete();
    obs_err = 0;
    chk_led = 0;
    chk_frm = 0;
    check_eq("rst_led_valid", led_valid, 1'b0);
    check_eq("rst_fields", {led_index, led_bright, led_b, led_g, led_r}, '0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_led_count", led_count, 7'd0);
    check_eq("rst_frame_bits", frame_bits, 64'd0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_state", dbg_state, matrix_pkg::HUNT);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    n_checks = 0; n_errors = 0; obs_err = 0; exp_err = 0; chk_led = 0; chk_frm = 0;
    reset = 1'b1; sclk_in = 1'b0; sdata_in = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();

    // Single LED frame.
    send_zeros(SZ);
    send_word(32'hf0000f00, 32);
    send_zeros(SZ);
    compare_model();
    if (obs_led_q.size() > 0) check_eq("t1_led", obs_led_q[0], {6'd0, 5'h10, 8'h00, 8'h0f, 8'h00});
    if (obs_frm_q.size() > 0) check_eq("t1_frame", obs_frm_q[0], {7'd1, 64'h80});

    // Full 64-LED frame in driver format.
    send_zeros(SZ);
    for (int k = 0; k < 64; k++)
      send_word((k == 0 || k == 8 || k == 9) ? 32'hf0000f00 : 32'hf0070000, 32);
    send_zeros(64);
    compare_model();
    check_eq("t2_n_led", obs_led_q.size(), 65);
    if (obs_frm_q.size() > 1) check_eq("t2_frame", obs_frm_q[1], {7'd64, 64'h380});

    // 31 zeros then a 1 must not start a frame.
    apply_reset();
    send_zeros(31);
    drive_bit(1'b1);
    check_eq("t3_state", dbg_state, matrix_pkg::HUNT);
    send_zeros(SZ);
    send_word(32'he0ffffff, 32);
    send_zeros(SZ);
    compare_model();
    if (obs_led_q.size() > 0) check_eq("t3_bright", obs_led_q[0][28:24], 5'd0);
    if (obs_frm_q.size() > 0) check_eq("t3_frame", obs_frm_q[0], {7'd1, 64'h0});

    // Bad header, then recovery.
    send_word(32'h80000000, 32);
    repeat (8) @(negedge clk);
    check_eq("t4_err", obs_err, 1);
    check_eq("t4_no_led", obs_led_q.size(), 1);
    send_zeros(SZ);
    send_word(rand_word(), 32);
    send_zeros(SZ);
    compare_model();

    // 70 words: only NUM_LEDS captured.
    send_zeros(SZ);
    for (int k = 0; k < 70; k++) send_word(rand_word(), 32);
    send_zeros(SZ);
    compare_model();
    if (obs_frm_q.size() > 0) check_eq("t5_count", obs_frm_q[obs_frm_q.size()-1][70:64], 7'd64);
    if (exp_led_q.size() > 0)
      check_eq("t5_hold", {led_index, led_bright, led_b, led_g, led_r}, exp_led_q[exp_led_q.size()-1]);

    // Random frames, occasionally with a corrupted header.
    for (int f = 0; f < 4; f++) begin
      send_zeros($urandom_range(SZ, SZ + 8));
      for (int k = 0, nw = $urandom_range(1, 12); k < nw; k++) begin
        w = rand_word();
        if ($urandom_range(0, 15) == 0) w[31:29] = 3'($urandom_range(0, 6));
        send_word(w, 32);
      end
      send_zeros($urandom_range(SZ, SZ + 8));
      compare_model();
    end

    // Reset in the middle of word 5.
    apply_reset();
    send_zeros(SZ);
    for (int k = 0; k < 5; k++) send_word(rand_word(), 32);
    send_word(rand_word(), 17);
    apply_reset();
    repeat (20) @(negedge clk);
    check_eq("t6_no_done", obs_frm_q.size(), 0);
    send_zeros(SZ);
    for (int k = 0; k < 64; k++) send_word(rand_word(), 32);
    send_zeros(SZ);
    compare_model();
    check_eq("t6_frames", obs_frm_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
